// File: rtl/branch_resolve_unit_if.sv
// Branch compare encodings shared with decode, plus the handshake bundle
// between register read/ALU, the resolve stage and the fetch redirect logic.
package cpu_pkg;
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } t_branch_cond_op;
endpackage

interface branch_resolve_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    import cpu_pkg::*;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data1;
    logic [DATA_W-1:0]     in_data2;
    t_branch_cond_op       in_op;
    logic [ADDR_W-1:0]     in_pc;
    logic [ADDR_W-1:0]     in_target;
    logic                  in_pred_taken;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_taken;
    logic [ADDR_W-1:0]     out_next_pc;
    logic                  out_mispredict;
    logic                  clear_stats;
    logic [CNT_W-1:0]      stat_branches;
    logic [CNT_W-1:0]      stat_mispredicts;

    modport slave (
        input  flush, in_valid, in_data1, in_data2, in_op, in_pc, in_target,
               in_pred_taken, out_ready, clear_stats,
        output in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
               stat_branches, stat_mispredicts
    );

    modport master (
        output flush, in_valid, in_data1, in_data2, in_op, in_pc, in_target,
               in_pred_taken, out_ready, clear_stats,
        input  in_ready, out_valid, out_taken, out_next_pc, out_mispredict,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves one branch per handshake into a registered taken/next-PC/mispredict result.
// Latency 1 cycle; in_ready drops while the held result is stalled or during flush.
module branch_resolve_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    parameter int PC_INC = 4
) (
    input logic                    clk,
    input logic                    rst,
    branch_resolve_unit_if.slave   bus
);
    import cpu_pkg::*;

    logic               valid_q, valid_d;
    logic               taken_q, taken_d;
    logic [ADDR_W-1:0]  next_pc_q, next_pc_d;
    logic               mispredict_q, mispredict_d;
    logic [CNT_W-1:0]   br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]   mp_cnt_q, mp_cnt_d;

    logic cond_taken;
    logic accept;
    logic xfer;

    assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign xfer         = valid_q && bus.out_ready;

    always_comb begin
        cond_taken = 1'b0;
        case (bus.in_op)
            BR_BEQ:  cond_taken = (bus.in_data1 == bus.in_data2);
            BR_BNE:  cond_taken = (bus.in_data1 != bus.in_data2);
            BR_BLT:  cond_taken = ($signed(bus.in_data1) <  $signed(bus.in_data2));
            BR_BGE:  cond_taken = ($signed(bus.in_data1) >= $signed(bus.in_data2));
            BR_BLTU: cond_taken = (bus.in_data1 <  bus.in_data2);
            BR_BGEU: cond_taken = (bus.in_data1 >= bus.in_data2);
            default: cond_taken = 1'b0;
        endcase
    end

    always_comb begin
        valid_d      = valid_q;
        taken_d      = taken_q;
        next_pc_d    = next_pc_q;
        mispredict_d = mispredict_q;
        br_cnt_d     = br_cnt_q;
        mp_cnt_d     = mp_cnt_q;

        // accept already implies !flush, so flush simply wins here
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d      = 1'b1;
            taken_d      = cond_taken;
            next_pc_d    = cond_taken ? bus.in_target : bus.in_pc + ADDR_W'(PC_INC);
            mispredict_d = cond_taken ^ bus.in_pred_taken;
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        if (bus.clear_stats) begin
            br_cnt_d = '0;
            mp_cnt_d = '0;
        end else if (xfer) begin
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + 1'b1;
            if (mispredict_q && (mp_cnt_q != '1))
                mp_cnt_d = mp_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            next_pc_q    <= '0;
            mispredict_q <= 1'b0;
            br_cnt_q     <= '0;
            mp_cnt_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            taken_q      <= taken_d;
            next_pc_q    <= next_pc_d;
            mispredict_q <= mispredict_d;
            br_cnt_q     <= br_cnt_d;
            mp_cnt_q     <= mp_cnt_d;
        end
    end

    assign bus.out_valid        = valid_q;
    assign bus.out_taken        = taken_q;
    assign bus.out_next_pc      = next_pc_q;
    assign bus.out_mispredict   = mispredict_q;
    assign bus.stat_branches    = br_cnt_q;
    assign bus.stat_mispredicts = mp_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: driver pushes model results, monitor checks them.
module tb_branch_resolve_unit;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    typedef struct {
        bit           taken;
        bit [AW-1:0]  npc;
        bit           mp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rand_rdy  = 1'b0;
    bit   rdy_force = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   exp_br = 0;
    int   exp_mp = 0;
    exp_t sb_q[$];
    exp_t e;
    bit   xfer;

    branch_resolve_unit_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    branch_resolve_unit #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .PC_INC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference condition evaluation from plain signed/unsigned arithmetic
    function automatic bit ref_taken(input int op, input bit [DW-1:0] a, input bit [DW-1:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        case (op)
            0:       return a == b;
            1:       return a != b;
            4:       return sa < sb;
            5:       return sa >= sb;
            6:       return ua < ub;
            7:       return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        #2;
        bus.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            exp_br = 0;
            exp_mp = 0;
        end else begin
            chk("out_valid", bus.out_valid, sb_q.size() != 0);
            chk("in_ready", bus.in_ready, !bus.flush && (sb_q.size() == 0 || bus.out_ready));
            if (sb_q.size() != 0) begin
                e = sb_q[0];
                chk("out_taken", bus.out_taken, e.taken);
                chk("out_next_pc", bus.out_next_pc, e.npc);
                chk("out_mispredict", bus.out_mispredict, e.mp);
            end
            chk("stat_branches", bus.stat_branches, exp_br);
            chk("stat_mispredicts", bus.stat_mispredicts, exp_mp);
            xfer = (sb_q.size() != 0) && bus.out_ready;
            if (sb_q.size() != 0 && (bus.out_ready || bus.flush))
                void'(sb_q.pop_front());
            if (bus.clear_stats) begin
                exp_br = 0;
                exp_mp = 0;
            end else if (xfer) begin
                if (exp_br < CNTMAX) exp_br++;
                if (e.mp && exp_mp < CNTMAX) exp_mp++;
            end
        end
    end

    task automatic send(input int op, input bit [DW-1:0] a, input bit [DW-1:0] b,
                        input bit [AW-1:0] pc, input bit [AW-1:0] tgt, input bit pred);
        bit   got = 1'b0;
        bit   t;
        exp_t x;
        bus.in_valid      = 1'b1;
        bus.in_op         = cpu_pkg::t_branch_cond_op'(op[2:0]);
        bus.in_data1      = a;
        bus.in_data2      = b;
        bus.in_pc         = pc;
        bus.in_target     = tgt;
        bus.in_pred_taken = pred;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            chk("accept_timeout", 0, 1);
            bus.in_valid = 1'b0;
            return;
        end
        t     = ref_taken(op, a, b);
        x.taken = t;
        x.npc   = t ? tgt : pc + 4;
        x.mp    = t ^ pred;
        @(posedge clk);
        sb_q.push_back(x);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (sb_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic send_rand();
        bit [DW-1:0] a = $urandom;
        bit [DW-1:0] b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
        send(int'($urandom_range(0, 7)), a, b, $urandom, $urandom, 1'($urandom_range(0, 1)));
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.clear_stats = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_op = cpu_pkg::BR_BEQ;
        bus.in_data1 = '0;
        bus.in_data2 = '0;
        bus.in_pc = '0;
        bus.in_target = '0;
        bus.in_pred_taken = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_taken", bus.out_taken, 0);
        chk("rst_out_next_pc", bus.out_next_pc, 0);
        chk("rst_out_mispredict", bus.out_mispredict, 0);
        chk("rst_stat_branches", bus.stat_branches, 0);
        chk("rst_stat_mispredicts", bus.stat_mispredicts, 0);

        rdy_force = 1'b1;
        send(0, 32'h5, 32'h5, 32'h100, 32'h200, 1'b0);
        drain();
        chk("beq_stat_branches", bus.stat_branches, 1);
        chk("beq_stat_mispredicts", bus.stat_mispredicts, 1);

        send(4, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h400, 1'b1);
        send(6, 32'hFFFF_FFFF, 32'h1, 32'h304, 32'h500, 1'b1);
        send(5, 32'hFFFF_FFFF, 32'h1, 32'h308, 32'h600, 1'b0);
        send(7, 32'hFFFF_FFFF, 32'h1, 32'h30C, 32'h700, 1'b0);
        drain();

        // stall the output with more work waiting, then release
        rdy_force = 1'b0;
        fork
            begin
                send(1, 32'h1, 32'h2, 32'h1000, 32'h2000, 1'b1);
                send(0, 32'h1, 32'h2, 32'h1004, 32'h2004, 1'b1);
                send(6, 32'h1, 32'h2, 32'h1008, 32'h2008, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 rdy_force = 1'b1;
            end
        join
        drain();

        rdy_force = 1'b0;
        send(0, 32'h7, 32'h7, 32'h40, 32'h80, 1'b1);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_op = cpu_pkg::BR_BNE;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", bus.out_valid, 0);
        rdy_force = 1'b1;
        @(posedge clk);
        #1;

        send(1, 32'h9, 32'h9, 32'hFFFF_FFFC, 32'h1234, 1'b0);
        send(3, 32'h9, 32'h9, 32'h500, 32'h900, 1'b1);
        send(2, 32'h1, 32'h2, 32'h600, 32'hA00, 1'b0);
        drain();

        bus.clear_stats = 1'b1;
        @(posedge clk);
        #1 bus.clear_stats = 1'b0;
        rand_rdy = 1'b1;
        for (int i = 0; i < 25; i++) send_rand();
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_stat_branches", bus.stat_branches, CNTMAX);

        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(0, 32'h3, 32'h4, 32'h80, 32'h90, 1'b1);
        bus.clear_stats = 1'b1;
        rdy_force = 1'b1;
        @(posedge clk);
        #1 bus.clear_stats = 1'b0;
        chk("clr_stat_branches", bus.stat_branches, 0);
        chk("clr_stat_mispredicts", bus.stat_mispredicts, 0);

        rdy_force = 1'b0;
        @(posedge clk);
        #1;
        send(5, 32'h8, 32'h2, 32'hC0, 32'hD0, 1'b0);
        #3 rst = 1'b1;
        #1 chk("async_rst_out_valid", bus.out_valid, 0);
        chk("async_rst_stat_branches", bus.stat_branches, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        rdy_force = 1'b1;
        send(7, 32'h2, 32'h8, 32'hE0, 32'hF0, 1'b1);
        drain();
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
